spi_slave: RTL and testbench

SPI responder: the peripheral end of the project's SPI link (`sclk`, `mosi`, `miso`, `load`), mode 0, MSB first. It oversamples the incoming serial lines in the `clk` domain and shifts out a parallel word on `miso` while capturing the `mosi` word. It presents the received word with a one-cycle valid strobe. It sits opposite the SPI master on the board and loops back to it for self-test.

---
 rtl/spi_slave_pkg.sv | 23 ++
 rtl/spi_slave_if.sv | 18 +
 rtl/spi_slave_sync2.sv | 33 +++
 rtl/spi_slave.sv | 166 ++++++++++++++++
 tb/tb_spi_slave.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/spi_slave_pkg.sv
// ============================================================================
//  Module   : spi_slave_pkg
//  Brief    : Shared constants and FSM encoding for the SPI responder.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package spi_slave_pkg;

    localparam int   SPI_WIDTH_DEFAULT = 13;
    localparam logic SPI_SCLK_IDLE     = 1'b0;
    localparam logic SPI_LOAD_IDLE     = 1'b1;
    localparam logic SPI_MOSI_IDLE     = 1'b0;
    localparam int   SPI_SYNC_DEPTH    = 2;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } spi_state_e;

endpackage

`default_nettype wire

// File: rtl/spi_slave_if.sv
// ============================================================================
//  Module   : spi_slave_if
//  Brief    : SPI pin bundle between master and responder.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface spi_slave_if;
    logic sclk;
    logic mosi;
    logic load;
    logic miso;

    modport master (output sclk, output mosi, output load, input miso);
    modport slave  (input sclk, input mosi, input load, output miso);
endinterface

`default_nettype wire

// File: rtl/spi_slave_sync2.sv
// ============================================================================
//  Module   : sync2
//  Brief    : Two-flop synchronizer, async active-low reset to RESET_VAL.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync2
    import spi_slave_pkg::*;
#(
    parameter logic RESET_VAL = 1'b0
) (
    input  wire logic clk,
    input  wire logic rst_n,
    input  wire logic i_d,
    output logic      o_q
);

    logic [SPI_SYNC_DEPTH-1:0] r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= {SPI_SYNC_DEPTH{RESET_VAL}};
        end else begin
            r_sync <= {r_sync[SPI_SYNC_DEPTH-2:0], i_d};
        end
    end

    assign o_q = r_sync[SPI_SYNC_DEPTH-1];

endmodule

`default_nettype wire

// File: rtl/spi_slave.sv
// ============================================================================
//  Module   : spi_slave
//  Brief    : Mode-0 MSB-first SPI responder, oversampled in the clk domain.
//             Optional frame checking under SPI_SLAVE_FRAME_CHECK_EN.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_slave
    import spi_slave_pkg::*;
#(
    parameter int WIDTH = SPI_WIDTH_DEFAULT
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    spi_slave_if.slave            spi,
    input  wire logic [WIDTH-1:0] tx_dat,
    output logic      [WIDTH-1:0] rx_dat,
    output logic                  rx_valid,
    output logic                  busy,
    output logic                  frame_err
);

    localparam int               CNT_W  = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] C_FULL = CNT_W'(WIDTH);

    logic w_sclk_s, w_mosi_s, w_load_s;
    logic r_sclk_d, r_load_d;

    sync2 #(.RESET_VAL(SPI_SCLK_IDLE)) u_sync_sclk (.clk(clk), .rst_n(rst_n), .i_d(spi.sclk), .o_q(w_sclk_s));
    sync2 #(.RESET_VAL(SPI_MOSI_IDLE)) u_sync_mosi (.clk(clk), .rst_n(rst_n), .i_d(spi.mosi), .o_q(w_mosi_s));
    sync2 #(.RESET_VAL(SPI_LOAD_IDLE)) u_sync_load (.clk(clk), .rst_n(rst_n), .i_d(spi.load), .o_q(w_load_s));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sclk_d <= SPI_SCLK_IDLE;
            r_load_d <= SPI_LOAD_IDLE;
        end else begin
            r_sclk_d <= w_sclk_s;
            r_load_d <= w_load_s;
        end
    end

    logic w_sclk_rise, w_sclk_fall, w_load_rise, w_load_fall;
    assign w_sclk_rise =  w_sclk_s & ~r_sclk_d;
    assign w_sclk_fall = ~w_sclk_s &  r_sclk_d;
    assign w_load_rise =  w_load_s & ~r_load_d;
    assign w_load_fall = ~w_load_s &  r_load_d;

    spi_state_e       r_state,    w_state_nxt;
    logic [WIDTH-1:0] r_tx_sh,    w_tx_sh_nxt;
    logic [WIDTH-1:0] r_rx_sh,    w_rx_sh_nxt;
    logic [WIDTH-1:0] r_rx_dat,   w_rx_dat_nxt;
    logic [CNT_W-1:0] r_bit_cnt,  w_bit_cnt_nxt;
    logic             r_miso,     w_miso_nxt;
    logic             r_rx_valid, w_rx_valid_nxt;
`ifdef SPI_SLAVE_FRAME_CHECK_EN
    logic             r_ovr,      w_ovr_nxt;
    logic             r_err,      w_err_nxt;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_tx_sh    <= '0;
            r_rx_sh    <= '0;
            r_rx_dat   <= '0;
            r_bit_cnt  <= '0;
            r_miso     <= 1'b0;
            r_rx_valid <= 1'b0;
`ifdef SPI_SLAVE_FRAME_CHECK_EN
            r_ovr      <= 1'b0;
            r_err      <= 1'b0;
`endif
        end else begin
            r_state    <= w_state_nxt;
            r_tx_sh    <= w_tx_sh_nxt;
            r_rx_sh    <= w_rx_sh_nxt;
            r_rx_dat   <= w_rx_dat_nxt;
            r_bit_cnt  <= w_bit_cnt_nxt;
            r_miso     <= w_miso_nxt;
            r_rx_valid <= w_rx_valid_nxt;
`ifdef SPI_SLAVE_FRAME_CHECK_EN
            r_ovr      <= w_ovr_nxt;
            r_err      <= w_err_nxt;
`endif
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_tx_sh_nxt    = r_tx_sh;
        w_rx_sh_nxt    = r_rx_sh;
        w_rx_dat_nxt   = r_rx_dat;
        w_bit_cnt_nxt  = r_bit_cnt;
        w_miso_nxt     = r_miso;
        w_rx_valid_nxt = 1'b0;
`ifdef SPI_SLAVE_FRAME_CHECK_EN
        w_ovr_nxt      = r_ovr;
        w_err_nxt      = 1'b0;
`endif
        case (r_state)
            ST_IDLE: begin
                w_miso_nxt = 1'b0;
                if (w_load_fall) begin
                    w_tx_sh_nxt   = tx_dat;
                    w_miso_nxt    = tx_dat[WIDTH-1];
                    w_bit_cnt_nxt = '0;
`ifdef SPI_SLAVE_FRAME_CHECK_EN
                    w_ovr_nxt     = 1'b0;
`endif
                    w_state_nxt   = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (w_sclk_rise) begin
                    if (r_bit_cnt < C_FULL) begin
                        w_rx_sh_nxt   = {r_rx_sh[WIDTH-2:0], w_mosi_s};
                        w_bit_cnt_nxt = r_bit_cnt + 1'b1;
                    end
`ifdef SPI_SLAVE_FRAME_CHECK_EN
                    else begin
                        w_ovr_nxt = 1'b1;
                    end
`endif
                end
                if (w_sclk_fall && (r_bit_cnt < C_FULL)) begin
                    w_tx_sh_nxt = {r_tx_sh[WIDTH-2:0], 1'b0};
                    w_miso_nxt  = r_tx_sh[WIDTH-2];
                end
                // End-of-frame decision sees any sclk edge from this same cycle
                if (w_load_rise) begin
                    w_state_nxt = ST_IDLE;
                    w_miso_nxt  = 1'b0;
`ifdef SPI_SLAVE_FRAME_CHECK_EN
                    if ((w_bit_cnt_nxt == C_FULL) && !w_ovr_nxt) begin
                        w_rx_dat_nxt   = w_rx_sh_nxt;
                        w_rx_valid_nxt = 1'b1;
                    end else begin
                        w_err_nxt = 1'b1;
                    end
`else
                    if (w_bit_cnt_nxt == C_FULL) begin
                        w_rx_dat_nxt   = w_rx_sh_nxt;
                        w_rx_valid_nxt = 1'b1;
                    end
`endif
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign spi.miso = r_miso;
    assign rx_dat   = r_rx_dat;
    assign rx_valid = r_rx_valid;
    assign busy     = (r_state == ST_SHIFT);
`ifdef SPI_SLAVE_FRAME_CHECK_EN
    assign frame_err = r_err;
`else
    assign frame_err = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_spi_slave.sv
// ============================================================================
//  Module   : tb_spi_slave
//  Brief    : Self-checking bench for spi_slave (table, directed, random).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_spi_slave;
    localparam int W = 13;
`ifdef SPI_SLAVE_FRAME_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] tx_dat;
    logic [W-1:0] rx_dat;
    logic         rx_valid, busy, frame_err;

    always #5 clk = ~clk;

    spi_slave_if spi ();

    spi_slave #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .spi(spi), .tx_dat(tx_dat),
        .rx_dat(rx_dat), .rx_valid(rx_valid), .busy(busy), .frame_err(frame_err)
    );

    int n_checks = 0;
    int n_errors = 0;
    int n_valid  = 0;
    int n_err    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Pulse counting and rx_valid/rx_dat behaviour between frames
    logic         prev_valid = 1'b0;
    logic         prev_rst   = 1'b0;
    logic [W-1:0] prev_rx    = '0;
    always @(negedge clk) begin
        if (rx_valid)  n_valid++;
        if (frame_err) n_err++;
        if (prev_valid) check("valid_width", rx_valid, 1'b0);
        if (rst_n && prev_rst && !rx_valid) check("rx_dat_hold", rx_dat, prev_rx);
        prev_valid = rx_valid;
        prev_rst   = rst_n;
        prev_rx    = rx_dat;
    end

    // Reference: a frame of n bits yields the first W bits it carried
    task automatic model(input logic [15:0] bits, input int n,
                         output logic v, output logic e, inout logic [W-1:0] rx);
        logic [15:0] t;
        v = CHK ? (n == W) : (n >= W);
        e = CHK && (n != W);
        if (v) begin
            t  = bits >> (n - W);
            rx = t[W-1:0];
        end
    endtask

    task automatic run_frame(input string tag, input logic [15:0] bits, input int n,
                             input logic [W-1:0] tx, input int h, input int gap,
                             input logic exp_v, input logic exp_e, input logic [W-1:0] exp_rx);
        logic [W-1:0] cap  = '0;
        logic [W-1:0] mask = '0;
        int v0 = n_valid;
        int e0 = n_err;
        tx_dat   = tx;
        spi.load = 1'b0;
        tick(5);
        for (int i = 0; i < n; i++) begin
            spi.mosi = bits[n-1-i];
            tick(h);
            spi.sclk = 1'b1;
            if (i < W) begin
                cap[W-1-i]  = spi.miso;
                mask[W-1-i] = 1'b1;
            end
            if (i == 0) begin
                check({tag, "/busy"}, busy, 1'b1);
                tx_dat = ~tx;
            end
            tick(h);
            spi.sclk = 1'b0;
        end
        tick(5);
        spi.load = 1'b1;
        spi.mosi = 1'b0;
        tick(2);
        check({tag, "/valid_early"}, rx_valid, 1'b0);
        tick(1);
        check({tag, "/valid_lat"}, rx_valid, exp_v);
        check({tag, "/err_lat"}, frame_err, exp_e);
        tick(gap);
        check({tag, "/miso_cap"}, cap & mask, tx & mask);
        check({tag, "/n_valid"}, n_valid - v0, exp_v);
        check({tag, "/n_err"}, n_err - e0, exp_e);
        check({tag, "/rx_dat"}, rx_dat, exp_rx);
        check({tag, "/idle"}, busy, 1'b0);
    endtask

    typedef struct {
        logic [15:0]  bits;
        int           n;
        logic [W-1:0] tx;
        int           h;
        int           gap;
        logic         v;
        logic         e;
        logic [W-1:0] rx;
    } vec_t;

    vec_t tbl [6];

    initial begin
        logic [W-1:0] exp_rx;
        logic         ev, ee;
        int           v0;

        tbl[0] = '{16'h1dad, 13, 13'h0ced, 6, 6, 1'b1, 1'b0, 13'h1dad};
        tbl[1] = '{16'h0abc, 12, 13'h1234, 5, 6, 1'b0, CHK,  13'h1dad};
        tbl[2] = '{16'h3ffe, 14, 13'h0f0f, 4, 6, !CHK, CHK,  CHK ? 13'h1dad : 13'h1fff};
        tbl[3] = '{16'h0000, 0,  13'h1555, 4, 6, 1'b0, CHK,  CHK ? 13'h1dad : 13'h1fff};
        tbl[4] = '{16'h0aaa, 13, 13'h0123, 4, 1, 1'b1, 1'b0, 13'h0aaa};
        tbl[5] = '{16'h1555, 13, 13'h1abc, 4, 6, 1'b1, 1'b0, 13'h1555};

        spi.sclk = 1'b0;
        spi.mosi = 1'b0;
        spi.load = 1'b1;
        tx_dat   = '0;
        rst_n    = 1'b0;
        tick(3);
        rst_n = 1'b1;
        tick(4);
        check("reset/rx_dat", rx_dat, 0);
        check("reset/rx_valid", rx_valid, 0);
        check("reset/busy", busy, 0);
        check("reset/miso", spi.miso, 0);
        check("reset/frame_err", frame_err, 0);

        for (int i = 0; i < 6; i++) begin
            run_frame($sformatf("vec%0d", i), tbl[i].bits, tbl[i].n, tbl[i].tx,
                      tbl[i].h, tbl[i].gap, tbl[i].v, tbl[i].e, tbl[i].rx);
        end

        // Reset asserted during bit 6, released while load is still low
        v0       = n_valid;
        tx_dat   = 13'h1111;
        spi.load = 1'b0;
        tick(5);
        for (int i = 0; i < 6; i++) begin
            spi.mosi = i[0];
            tick(4); spi.sclk = 1'b1;
            tick(4); spi.sclk = 1'b0;
        end
        rst_n = 1'b0;
        tick(1);
        check("midreset/rx_dat", rx_dat, 0);
        check("midreset/busy", busy, 0);
        check("midreset/miso", spi.miso, 0);
        check("midreset/rx_valid", rx_valid, 0);
        tick(2);
        rst_n = 1'b1;
        tick(2);
        for (int i = 0; i < 7; i++) begin
            spi.mosi = 1'b1;
            tick(4); spi.sclk = 1'b1;
            tick(4); spi.sclk = 1'b0;
        end
        tick(5);
        spi.load = 1'b1;
        spi.mosi = 1'b0;
        tick(8);
        check("midreset/no_capture", n_valid - v0, 0);
        check("midreset/rx_dat_after", rx_dat, 0);
        run_frame("post_reset", 16'h0001, 13, 13'h0f00, 5, 6, 1'b1, 1'b0, 13'h0001);
        exp_rx = 13'h0001;

        // sclk activity with load high must be ignored
        v0 = n_valid;
        for (int i = 0; i < 5; i++) begin
            spi.mosi = 1'b1;
            spi.sclk = 1'b1;
            tick(4);
            check("idle_sclk/busy", busy, 0);
            check("idle_sclk/miso", spi.miso, 0);
            spi.sclk = 1'b0;
            tick(4);
        end
        spi.mosi = 1'b0;
        tick(4);
        check("idle_sclk/no_valid", n_valid - v0, 0);
        check("idle_sclk/rx_dat", rx_dat, exp_rx);

        for (int i = 0; i < 30; i++) begin
            logic [15:0]  bits;
            logic [W-1:0] tx;
            int           n, r;
            r    = $urandom_range(0, 9);
            n    = (r < 6) ? 13 : (r == 6) ? 12 : (r == 7) ? 14 : $urandom_range(10, 15);
            bits = 16'($urandom);
            tx   = W'($urandom);
            model(bits, n, ev, ee, exp_rx);
            run_frame($sformatf("rnd%0d", i), bits, n, tx, $urandom_range(4, 7),
                      $urandom_range(1, 6), ev, ee, exp_rx);
        end

        tick(5);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
